// File: rtl/pulse_seq_ctrl_if.sv
// Descriptor write channel into the pulse sequencer FIFO.
// The master drives the descriptor fields; the slave returns ready when the FIFO has room.
interface pulse_seq_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [10:0] cmd_width;
  logic [10:0] cmd_num;
  logic [15:0] cmd_gap_us;

  modport master (
    output cmd_valid,
    output cmd_width,
    output cmd_num,
    output cmd_gap_us,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_width,
    input  cmd_num,
    input  cmd_gap_us,
    output cmd_ready
  );
endinterface

// File: rtl/pulse_seq_ctrl.sv
// Sequences queued pulse-train descriptors into the OSERDES pulse generator: load, settle,
// strobe start, wait for done. Includes an optional watchdog on the generator's done pulse.
module pulse_seq_ctrl #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  pulse_seq_ctrl_if.slave          cmd,
  input  logic                     run_i,
  input  logic                     abort_i,
  input  logic                     clear_err_i,
  output logic [10:0]              pulse_width_o,
  output logic [10:0]              pulse_num_o,
  output logic [15:0]              gap_us_o,
  output logic                     start_o,
  input  logic                     gen_done_i,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     cmd_err_o,
  output logic                     seq_done_o,
  output logic                     timeout_err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [2:0] {StIdle, StLoad, StSettle, StStart, StWait} state_e;

  typedef struct packed {
    logic [10:0] width;
    logic [10:0] num;
    logic [15:0] gap;
  } desc_t;

  desc_t          mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]  level_q, level_d;
  logic           cmd_ready_q;

  state_e         state_q, state_d;
  logic [31:0]    cnt_q, cnt_d;
  logic           aborted_q, aborted_d;

  logic [10:0]    width_q, num_q;
  logic [15:0]    gap_q;
  logic           start_q, busy_q, err_q, seq_done_q, seq_done_d, timeout_q;

  logic cmd_acc, cmd_bad, push, pop, flush, timeout_hit;

  assign cmd_acc = cmd.cmd_valid & cmd_ready_q;
  assign cmd_bad = (cmd.cmd_num == 11'd0) | (cmd.cmd_gap_us == 16'd0);
  assign timeout_hit = (TIMEOUT_CYC != 0) && (state_q == StWait) && !gen_done_i &&
                       (cnt_q == TIMEOUT_CYC - 32'd1);
  assign flush = abort_i | timeout_hit;
  // A write landing in a flush cycle is discarded along with the queue.
  assign push  = cmd_acc & ~cmd_bad & ~flush;
  assign pop   = (state_q == StLoad) & (level_q != '0);

  always_comb begin
    level_d = level_q;
    if (flush) begin
      level_d = '0;
    end else if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!push && pop) begin
      level_d = level_q - LW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    seq_done_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (run_i && level_q != '0 && !abort_i) state_d = StLoad;
      end
      StLoad: begin
        state_d = abort_i ? StIdle : StSettle;
      end
      StSettle: begin
        // Settling spans these cycles plus the START cycle, SETTLE_CYC in total.
        if (abort_i) begin
          state_d = StIdle;
        end else if (cnt_q == SETTLE_CYC - 32'd2) begin
          state_d = StStart;
        end
      end
      StStart: begin
        state_d = abort_i ? StIdle : StWait;
      end
      StWait: begin
        if (gen_done_i) begin
          if (aborted_q || abort_i) begin
            state_d = StIdle;
          end else if (run_i && level_q != '0) begin
            state_d = StLoad;
          end else begin
            state_d    = StIdle;
            seq_done_d = (level_q == '0);
          end
        end else if (timeout_hit) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign cnt_d     = (state_d == state_q) ? cnt_q + 32'd1 : 32'd0;
  assign aborted_d = (state_d == StWait) & (aborted_q | abort_i);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd.cmd_width, cmd.cmd_num, cmd.cmd_gap_us};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      aborted_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      cmd_ready_q <= 1'b1;
      width_q     <= '0;
      num_q       <= '0;
      gap_q       <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      seq_done_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      aborted_q   <= aborted_d;
      level_q     <= level_d;
      cmd_ready_q <= (level_d != LW'(DEPTH));
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (flush) begin
        rd_ptr_q <= wr_ptr_q;
      end else if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (pop) begin
        width_q <= mem_q[rd_ptr_q].width;
        num_q   <= mem_q[rd_ptr_q].num;
        gap_q   <= mem_q[rd_ptr_q].gap;
      end
      // Start is registered out of START so an abort seen in START still suppresses it.
      start_q    <= (state_q == StStart) & ~abort_i;
      busy_q     <= (state_d != StIdle);
      err_q      <= cmd_acc & cmd_bad;
      seq_done_q <= seq_done_d;
      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end else if (clear_err_i) begin
        timeout_q <= 1'b0;
      end
    end
  end

  assign cmd.cmd_ready  = cmd_ready_q;
  assign level_o        = level_q;
  assign pulse_width_o  = width_q;
  assign pulse_num_o    = num_q;
  assign gap_us_o       = gap_q;
  assign start_o        = start_q;
  assign busy_o         = busy_q;
  assign cmd_err_o      = err_q;
  assign seq_done_o     = seq_done_q;
  assign timeout_err_o  = timeout_q;

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Scoreboard bench for pulse_seq_ctrl: the driver queues expected events and timed probes,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pulse_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pulse_seq_ctrl_if cmd_if ();
  pulse_seq_ctrl_if wd_if ();

  logic        run, abort, clear_err, gen_done;
  logic [10:0] pulse_width, pulse_num;
  logic [15:0] gap_us;
  logic        start, busy, cmd_err, seq_done, timeout_err;
  logic [2:0]  level;

  logic        wd_run, wd_abort, wd_clear, wd_done;
  logic [10:0] wd_width, wd_num;
  logic [15:0] wd_gap;
  logic        wd_start, wd_busy, wd_err, wd_seq_done, wd_timeout;
  logic [2:0]  wd_level;

  pulse_seq_ctrl #(.DEPTH(4), .SETTLE_CYC(4), .TIMEOUT_CYC(0)) dut (
    .clk(clk), .rst(rst), .cmd(cmd_if), .run_i(run), .abort_i(abort), .clear_err_i(clear_err),
    .pulse_width_o(pulse_width), .pulse_num_o(pulse_num), .gap_us_o(gap_us), .start_o(start),
    .gen_done_i(gen_done), .busy_o(busy), .level_o(level), .cmd_err_o(cmd_err),
    .seq_done_o(seq_done), .timeout_err_o(timeout_err)
  );

  pulse_seq_ctrl #(.DEPTH(4), .SETTLE_CYC(4), .TIMEOUT_CYC(50)) dut_wd (
    .clk(clk), .rst(rst), .cmd(wd_if), .run_i(wd_run), .abort_i(wd_abort),
    .clear_err_i(wd_clear), .pulse_width_o(wd_width), .pulse_num_o(wd_num), .gap_us_o(wd_gap),
    .start_o(wd_start), .gen_done_i(wd_done), .busy_o(wd_busy), .level_o(wd_level),
    .cmd_err_o(wd_err), .seq_done_o(wd_seq_done), .timeout_err_o(wd_timeout)
  );

  localparam int SelLevel = 0, SelReady = 1, SelBusy = 2, SelWidth = 3, SelNum = 4, SelGap = 5;
  localparam int SelTmo = 6, SelWdLevel = 7, SelWdBusy = 8, SelWdStart = 9, SelWdTmo = 10;
  localparam int SelWdErr = 11;

  typedef struct { int cyc; int sel; int exp; string name; } chk_t;
  typedef struct { int cyc; int w; int n; int g; } start_t;

  chk_t   chk_q[$];
  start_t exp_start_q[$];
  int     exp_done_q[$];
  int     exp_err_q[$];
  int     n_cmp = 0;
  int     n_fail = 0;
  bit     finishing = 1'b0;

  function automatic int sample(int sel);
    case (sel)
      SelLevel:   return int'(level);
      SelReady:   return int'(cmd_if.cmd_ready);
      SelBusy:    return int'(busy);
      SelWidth:   return int'(pulse_width);
      SelNum:     return int'(pulse_num);
      SelGap:     return int'(gap_us);
      SelTmo:     return int'(timeout_err);
      SelWdLevel: return int'(wd_level);
      SelWdBusy:  return int'(wd_busy);
      SelWdStart: return int'(wd_start);
      SelWdTmo:   return int'(wd_timeout);
      SelWdErr:   return int'(wd_err);
      default:    return -1;
    endcase
  endfunction

  task automatic cmp(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic miss(string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: sole owner of the comparison counters.
  always @(negedge clk) begin : monitor
    start_t e;
    int     c;
    if (start) begin
      if (exp_start_q.size() == 0) begin
        miss("start_unexpected: got a start strobe, want none");
      end else begin
        e = exp_start_q.pop_front();
        cmp("start_cycle", cyc, e.cyc);
        cmp("start_width", int'(pulse_width), e.w);
        cmp("start_num", int'(pulse_num), e.n);
        cmp("start_gap", int'(gap_us), e.g);
      end
    end
    if (seq_done) begin
      if (exp_done_q.size() == 0) begin
        miss("seq_done_unexpected: got seq_done, want none");
      end else begin
        c = exp_done_q.pop_front();
        cmp("seq_done_cycle", cyc, c);
      end
    end
    if (cmd_err) begin
      if (exp_err_q.size() == 0) begin
        miss("cmd_err_unexpected: got cmd_err, want none");
      end else begin
        c = exp_err_q.pop_front();
        cmp("cmd_err_cycle", cyc, c);
      end
    end
    for (int i = chk_q.size() - 1; i >= 0; i--) begin
      if (chk_q[i].cyc == cyc) begin
        cmp(chk_q[i].name, sample(chk_q[i].sel), chk_q[i].exp);
        chk_q.delete(i);
      end else if (chk_q[i].cyc < cyc) begin
        miss({chk_q[i].name, ": probe never sampled"});
        chk_q.delete(i);
      end
    end
    if (finishing) begin
      foreach (exp_start_q[i]) miss("start_missing: expected start never seen");
      foreach (exp_done_q[i])  miss("seq_done_missing: expected seq_done never seen");
      foreach (exp_err_q[i])   miss("cmd_err_missing: expected cmd_err never seen");
      foreach (chk_q[i])       miss({chk_q[i].name, ": probe left pending"});
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic expect_at(int c, int sel, int exp, string name);
    chk_q.push_back('{c, sel, exp, name});
  endtask

  task automatic exp_start(int c, int w, int n, int g);
    exp_start_q.push_back('{c, w, n, g});
  endtask

  task automatic push_cmd(int w, int n, int g);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_width  = 11'(w);
    cmd_if.cmd_num    = 11'(n);
    cmd_if.cmd_gap_us = 16'(g);
    tick(1);
    cmd_if.cmd_valid  = 1'b0;
  endtask

  task automatic push_wd(int w, int n, int g);
    wd_if.cmd_valid  = 1'b1;
    wd_if.cmd_width  = 11'(w);
    wd_if.cmd_num    = 11'(n);
    wd_if.cmd_gap_us = 16'(g);
    tick(1);
    wd_if.cmd_valid  = 1'b0;
  endtask

  initial begin : driver
    int k, s, c, a;
    int ew[4] = '{100, 0, 2047, 7};
    int en[4] = '{5, 1, 2047, 9};
    int eg[4] = '{10, 1, 65535, 3};
    int dl[4] = '{10, 3, 20, 7};
    int d[4];

    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_width = '0; cmd_if.cmd_num = '0; cmd_if.cmd_gap_us = '0;
    wd_if.cmd_valid  = 1'b0; wd_if.cmd_width  = '0; wd_if.cmd_num  = '0; wd_if.cmd_gap_us  = '0;
    run = 0; abort = 0; clear_err = 0; gen_done = 0;
    wd_run = 0; wd_abort = 0; wd_clear = 0; wd_done = 0;

    // Reset values
    tick(3);
    rst = 1'b0;
    expect_at(cyc + 1, SelLevel, 0, "rst_level");
    expect_at(cyc + 1, SelReady, 1, "rst_ready");
    expect_at(cyc + 1, SelBusy,  0, "rst_busy");
    expect_at(cyc + 1, SelWidth, 0, "rst_width");
    expect_at(cyc + 1, SelNum,   0, "rst_num");
    expect_at(cyc + 1, SelGap,   0, "rst_gap");
    expect_at(cyc + 1, SelTmo,   0, "rst_timeout");
    tick(2);

    // Single run: start 6 cycles after the decision, seq_done 1 cycle after done
    push_cmd(13, 3, 2);
    expect_at(cyc + 1, SelLevel, 1, "single_level_push");
    k = cyc;
    run = 1'b1;
    s = k + 6;
    exp_start(s, 13, 3, 2);
    expect_at(k + 1, SelBusy, 1, "single_busy");
    expect_at(k + 2, SelWidth, 13, "single_width");
    expect_at(k + 2, SelNum, 3, "single_num");
    expect_at(k + 2, SelGap, 2, "single_gap");
    expect_at(k + 2, SelLevel, 0, "single_level_pop");
    expect_at(s + 50, SelWidth, 13, "single_width_held");
    expect_at(s + 99, SelTmo, 0, "single_no_watchdog");
    wait_until(s + 100);
    gen_done = 1'b1;
    exp_done_q.push_back(s + 101);
    expect_at(s + 101, SelBusy, 0, "single_idle");
    tick(1);
    gen_done = 1'b0;
    run = 1'b0;
    tick(3);

    // Queue of 4: fifth write stalls, back-to-back starts, one seq_done
    for (int i = 0; i < 4; i++) push_cmd(ew[i], en[i], eg[i]);
    expect_at(cyc + 1, SelLevel, 4, "queue_level_full");
    expect_at(cyc + 1, SelReady, 0, "queue_ready_full");
    c = cyc;
    expect_at(c + 3, SelLevel, 4, "queue_fifth_ignored");
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_width = 11'd55;
    cmd_if.cmd_num = 11'd55; cmd_if.cmd_gap_us = 16'd55;
    tick(2);
    cmd_if.cmd_valid = 1'b0;
    k = cyc;
    run = 1'b1;
    expect_at(k + 2, SelLevel, 3, "queue_level_after_pop");
    expect_at(k + 2, SelReady, 1, "queue_ready_after_pop");
    s = k + 6;
    for (int i = 0; i < 4; i++) begin
      exp_start(s, ew[i], en[i], eg[i]);
      expect_at(s + 2, SelWidth, ew[i], "queue_width_held");
      d[i] = s + dl[i];
      s = d[i] + 6;
    end
    exp_done_q.push_back(d[3] + 1);
    expect_at(d[3] + 1, SelBusy, 0, "queue_idle");
    for (int i = 0; i < 4; i++) begin
      wait_until(d[i]);
      gen_done = 1'b1;
      tick(1);
      gen_done = 1'b0;
      if (i == 0) begin
        // Stray done during SETTLE must be ignored
        wait_until(d[0] + 3);
        gen_done = 1'b1;
        tick(1);
        gen_done = 1'b0;
      end
    end
    run = 1'b0;
    tick(4);

    // Rejection: num=0 then gap=0
    run = 1'b1;
    c = cyc;
    exp_err_q.push_back(c + 1);
    exp_err_q.push_back(c + 2);
    expect_at(c + 3, SelLevel, 0, "reject_level");
    expect_at(c + 3, SelBusy, 0, "reject_busy");
    push_cmd(5, 0, 4);
    push_cmd(5, 4, 0);
    tick(10);
    run = 1'b0;
    tick(2);

    // Abort in WAIT_DONE with 2 entries queued
    push_cmd(21, 2, 5);
    push_cmd(22, 3, 6);
    push_cmd(23, 4, 7);
    k = cyc;
    run = 1'b1;
    exp_start(k + 6, 21, 2, 5);
    expect_at(k + 8, SelLevel, 2, "abort_level_before");
    a = k + 10;
    expect_at(a + 1, SelLevel, 0, "abort_level_flushed");
    expect_at(a + 1, SelBusy, 1, "abort_still_waiting");
    expect_at(a + 3, SelLevel, 0, "abort_write_discarded");
    expect_at(k + 21, SelBusy, 0, "abort_idle_after_done");
    wait_until(a);
    abort = 1'b1;
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_width = 11'd30;
    cmd_if.cmd_num = 11'd30; cmd_if.cmd_gap_us = 16'd30;
    tick(1);
    abort = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    wait_until(k + 20);
    gen_done = 1'b1;
    tick(1);
    gen_done = 1'b0;
    tick(20);
    run = 1'b0;
    tick(2);

    // Reset mid-SETTLE
    push_cmd(40, 41, 42);
    k = cyc;
    run = 1'b1;
    expect_at(k + 3, SelWidth, 40, "rstmid_loaded");
    expect_at(k + 4, SelWidth, 0, "rstmid_width");
    expect_at(k + 4, SelNum, 0, "rstmid_num");
    expect_at(k + 4, SelGap, 0, "rstmid_gap");
    expect_at(k + 4, SelBusy, 0, "rstmid_busy");
    expect_at(k + 4, SelLevel, 0, "rstmid_level");
    expect_at(k + 4, SelReady, 1, "rstmid_ready");
    wait_until(k + 3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(12);
    run = 1'b0;
    tick(2);

    // Watchdog: TIMEOUT_CYC=50, generator never reports done
    push_wd(60, 61, 62);
    push_wd(70, 71, 72);
    k = cyc;
    wd_run = 1'b1;
    expect_at(k + 2,  SelWdLevel, 1, "wd_level_after_pop");
    expect_at(k + 5,  SelWdStart, 0, "wd_start_early");
    expect_at(k + 6,  SelWdStart, 1, "wd_start");
    expect_at(k + 7,  SelWdStart, 0, "wd_start_one_cycle");
    expect_at(k + 55, SelWdTmo,   0, "wd_timeout_not_yet");
    expect_at(k + 55, SelWdBusy,  1, "wd_busy_waiting");
    expect_at(k + 56, SelWdTmo,   1, "wd_timeout_set");
    expect_at(k + 56, SelWdBusy,  0, "wd_idle");
    expect_at(k + 56, SelWdLevel, 0, "wd_flushed");
    expect_at(k + 60, SelWdTmo,   1, "wd_timeout_sticky");
    expect_at(k + 61, SelWdTmo,   0, "wd_timeout_cleared");
    expect_at(k + 70, SelWdBusy,  0, "wd_no_restart");
    expect_at(k + 70, SelWdErr,   0, "wd_no_cmd_err");
    wait_until(k + 60);
    wd_clear = 1'b1;
    tick(1);
    wd_clear = 1'b0;
    wait_until(k + 72);
    wd_run = 1'b0;

    tick(2);
    finishing = 1'b1;
    tick(5);
    $display("FAIL monitor_finish: monitor never reached the summary");
    $fatal(1);
  end

endmodule
